disasm_trace_streamer: RTL and testbench

DISASM_TRACE_STREAMER -- requirements
Module: disasm_trace_streamer

---
 rtl/disasm_trace_streamer_if.sv | 30 +++
 rtl/disasm_trace_streamer.sv | 198 +++++++++++++++++++
 tb/tb_disasm_trace_streamer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/disasm_trace_streamer_if.sv
// ============================================================================
// Module  : disasm_trace_streamer_if
// Brief   : Trace-entry input and character-stream output bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface disasm_trace_streamer_if;
  logic         trace_valid;
  logic [9:0]   trace_pc;
  logic [1:152] trace_text;
  logic         trace_ready;
  logic [7:0]   char_data;
  logic         char_valid;
  logic         char_ready;

  // Trace source and character sink together, facing the streamer.
  modport master (
    output trace_valid, trace_pc, trace_text, char_ready,
    input  trace_ready, char_data, char_valid
  );

  // The streamer itself.
  modport slave (
    input  trace_valid, trace_pc, trace_text, char_ready,
    output trace_ready, char_data, char_valid
  );
endinterface

`default_nettype wire

// File: rtl/disasm_trace_streamer.sv
// ============================================================================
// Module  : disasm_trace_streamer
// Brief   : Buffers {pc, disassembly text} entries and streams each as an
//           ASCII line "PPP: text\r\n". Define TRACE_DROP_EN to drop entries
//           when full (counted on drop_count) instead of back-pressuring.
// Revision: 1.0
// ============================================================================
`default_nettype none

module disasm_trace_streamer #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
`ifdef TRACE_DROP_EN
  output      logic [15:0]  drop_count,
`endif
  disasm_trace_streamer_if.slave bus
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]  C_LAST_BYTE = 5'd18;

  typedef enum logic [2:0] {IDLE, PC, SEP, TEXT, CR, LF} state_t;

  logic [9:0]   pc_mem_q   [FIFO_DEPTH];
  logic [1:152] text_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;

  logic         w_full, w_push, w_pop, w_ready;
  logic [9:0]   w_head_pc;
  logic [1:152] w_head_text;
  logic [7:0]   w_text_bytes [19];
  logic [7:0]   w_text_byte;
  logic [3:0]   w_nib;
  logic [7:0]   w_char_data;
  logic         w_char_valid;

  assign w_full = (count_q == C_FULL);

`ifdef TRACE_DROP_EN
  logic [15:0] drop_count_q;
  logic        w_drop;

  // A pop on the same edge frees the slot, so a full-time offer still fits.
  assign w_ready = 1'b1;
  assign w_push  = bus.trace_valid && (!w_full || w_pop);
  assign w_drop  = bus.trace_valid && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_q <= 16'h0000;
    end else if (w_drop && drop_count_q != 16'hFFFF) begin
      drop_count_q <= drop_count_q + 16'h0001;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign w_ready = !w_full;
  assign w_push  = bus.trace_valid && !w_full;
`endif

  assign bus.trace_ready = w_ready;

  // Storage needs no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]   <= bus.trace_pc;
      text_mem_q[wr_ptr_q] <= bus.trace_text;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      idx_q    <= 5'd0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign w_head_pc   = pc_mem_q[rd_ptr_q];
  assign w_head_text = text_mem_q[rd_ptr_q];

  always_comb begin
    for (int k = 0; k < 19; k++) begin
      w_text_bytes[k] = w_head_text[1 + 8*k +: 8];
    end
  end

  assign w_text_byte = w_text_bytes[idx_q];

  always_comb begin
    case (idx_q)
      5'd0:    w_nib = {2'b00, w_head_pc[9:8]};
      5'd1:    w_nib = w_head_pc[7:4];
      default: w_nib = w_head_pc[3:0];
    endcase
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    w_char_valid = 1'b0;
    w_char_data  = 8'h00;
    w_pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = PC;
          idx_d   = 5'd0;
        end
      end
      PC: begin
        w_char_valid = 1'b1;
        w_char_data  = hex_char(w_nib);
        if (bus.char_ready) begin
          if (idx_q == 5'd2) begin
            state_d = SEP;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      SEP: begin
        w_char_valid = 1'b1;
        w_char_data  = (idx_q == 5'd0) ? 8'h3A : 8'h20;
        if (bus.char_ready) begin
          if (idx_q == 5'd1) begin
            state_d = TEXT;
            idx_d   = 5'd0;
          end else begin
            idx_d = 5'd1;
          end
        end
      end
      TEXT: begin
        // Padding bytes cost one silent cycle; real characters wait for ready.
        w_char_data  = w_text_byte;
        w_char_valid = (w_text_byte != 8'h00);
        if (!w_char_valid || bus.char_ready) begin
          if (idx_q == C_LAST_BYTE) begin
            state_d = CR;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      CR: begin
        w_char_valid = 1'b1;
        w_char_data  = 8'h0D;
        if (bus.char_ready) state_d = LF;
      end
      LF: begin
        w_char_valid = 1'b1;
        w_char_data  = 8'h0A;
        if (bus.char_ready) begin
          state_d = IDLE;
          w_pop   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.char_valid = w_char_valid;
  assign bus.char_data  = w_char_data;

endmodule

`default_nettype wire

// File: tb/tb_disasm_trace_streamer.sv
// ============================================================================
// Module  : tb_disasm_trace_streamer
// Brief   : Scoreboard bench for disasm_trace_streamer (both TRACE_DROP_EN builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_disasm_trace_streamer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef TRACE_DROP_EN
  logic [15:0] drop_count;
`endif

  disasm_trace_streamer_if bus();

  disasm_trace_streamer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef TRACE_DROP_EN
    .drop_count (drop_count),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pushed_lines = 0;
  int done_lines   = 0;
  int drops_exp    = 0;
  int bytes_seen   = 0;
  int rdy_mode     = 0;
  logic [7:0] exp_q [$];
  string HX = "0123456789ABCDEF";

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:152] build_text(input string s);
    logic [1:152] t;
    int L;
    t = '0;
    L = s.len();
    for (int i = 0; i < L; i++) t[1 + 8*(19 - L + i) +: 8] = s[i];
    return t;
  endfunction

  // Reference line: three hex digits, ": ", non-null text bytes, CR LF.
  task automatic model_push(input logic [9:0] pc, input logic [1:152] txt);
    logic [11:0] p;
    logic [7:0] b;
    p = {2'b00, pc};
    exp_q.push_back(HX[p[11:8]]);
    exp_q.push_back(HX[p[7:4]]);
    exp_q.push_back(HX[p[3:0]]);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h20);
    for (int k = 0; k < 19; k++) begin
      b = txt[1 + 8*k +: 8];
      if (b != 8'h00) exp_q.push_back(b);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    pushed_lines++;
  endtask

  // Driver runs at posedge+1; the model occupancy is exact at that point.
  task automatic offer(input logic [9:0] pc, input logic [1:152] txt);
    int occ;
    int tries;
    bit done;
    tries = 0;
    done = 0;
    bus.trace_valid = 1'b1;
    bus.trace_pc    = pc;
    bus.trace_text  = txt;
    while (!done) begin
      occ = pushed_lines - done_lines;
`ifdef TRACE_DROP_EN
      chk(bus.trace_ready == 1'b1, "trace_ready_const", {31'd0, bus.trace_ready}, 32'd1);
      @(posedge clk); #1;
      if (occ < DEPTH) model_push(pc, txt);
      else drops_exp++;
      done = 1;
`else
      chk(bus.trace_ready == (occ < DEPTH), "trace_ready_vs_occ", {31'd0, bus.trace_ready}, {31'd0, occ < DEPTH});
      @(posedge clk); #1;
      if (occ < DEPTH) begin
        model_push(pc, txt);
        done = 1;
      end else if (++tries > 3000) begin
        chk(1'b0, "offer_timeout", tries, 3000);
        done = 1;
      end
`endif
    end
    bus.trace_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || pushed_lines != done_lines) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    chk(c < 5000, "drain_timeout", exp_q.size(), 0);
  endtask

  // Downstream ready pattern: 0 hold low, 1 hold high, 2 ~30%, 3 ~70%.
  initial begin
    bus.char_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.char_ready = 1'b0;
        1: bus.char_ready = 1'b1;
        2: bus.char_ready = ($urandom_range(0, 99) < 30);
        default: bus.char_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  bit held = 0;
  logic [7:0] held_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 0;
    end else begin
      if (held)
        chk(bus.char_valid && bus.char_data == held_data, "stall_stable",
            {23'd0, bus.char_valid, bus.char_data}, {23'd1, held_data});
      held = bus.char_valid && !bus.char_ready;
      held_data = bus.char_data;
      if (bus.char_valid && bus.char_ready) begin
        logic [7:0] e;
        bytes_seen++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", bus.char_data, 0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.char_data == e, "char_data", bus.char_data, e);
          if (e == 8'h0A) done_lines++;
        end
      end
    end
  end

  logic [1:152] t027, t028, t0;
  initial begin
    int base;
    int c;
    bus.trace_valid = 1'b0;
    bus.trace_pc    = '0;
    bus.trace_text  = '0;
    t027 = build_text("LOAD s0,5A ");
    t028 = build_text("Invalid Instruction");
    t0   = '0;

    #2;
    chk(bus.char_valid == 1'b0, "rst_char_valid", bus.char_valid, 0);
    chk(bus.char_data == 8'h00, "rst_char_data", bus.char_data, 0);
    chk(bus.trace_ready == 1'b1, "rst_trace_ready", bus.trace_ready, 1);
`ifdef TRACE_DROP_EN
    chk(drop_count == 16'h0, "rst_drop_count", drop_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Short line, always-ready sink, with first-character latency.
    rdy_mode = 1;
    offer(10'h012, t027);
    chk(bus.char_valid == 1'b0, "lat_idle_after_E", bus.char_valid, 0);
    @(posedge clk); #1;
    chk(bus.char_valid == 1'b1 && bus.char_data == 8'h30, "lat_first_char",
        {23'd0, bus.char_valid, bus.char_data}, {23'd1, 8'h30});
    drain();
    chk(bytes_seen == 18, "len_012_line", bytes_seen, 18);

    base = bytes_seen;
    offer(10'h3FF, t028);
    drain();
    chk(bytes_seen - base == 26, "len_3FF_line", bytes_seen - base, 26);

    rdy_mode = 2;
    offer(10'h012, t027);
    drain();

    base = bytes_seen;
    offer(10'h155, t0);
    drain();
    chk(bytes_seen - base == 7, "len_empty_text", bytes_seen - base, 7);

    // Six back-to-back entries against a stalled sink.
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) offer(10'(i * 37 + 1), build_text($sformatf("LINE %0d", i)));
`ifdef TRACE_DROP_EN
    for (int i = 4; i < 6; i++) offer(10'(i * 37 + 1), build_text($sformatf("LINE %0d", i)));
    chk(drop_count == 16'd2, "drop_count_two", drop_count, 2);
    chk(drops_exp == 2, "model_drops_two", drops_exp, 2);
    rdy_mode = 1;
`else
    chk(bus.trace_ready == 1'b0, "ready_low_when_full", bus.trace_ready, 0);
    rdy_mode = 3;
    for (int i = 4; i < 6; i++) offer(10'(i * 37 + 1), build_text($sformatf("LINE %0d", i)));
`endif
    drain();

    // Random entries with mixed padding and varying sink throughput.
    for (int n = 0; n < 25; n++) begin
      logic [1:152] t;
      logic [9:0] pc;
      rdy_mode = (n < 12) ? 2 : 3;
      pc = 10'($urandom);
      t = '0;
      if ($urandom_range(0, 5) != 0)
        for (int k = 0; k < 19; k++)
          if ($urandom_range(0, 2) != 0) t[1 + 8*k +: 8] = 8'($urandom_range(32, 126));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
`ifdef TRACE_DROP_EN
      c = 0;
      while (pushed_lines - done_lines >= DEPTH && c < 3000) begin @(posedge clk); #1; c++; end
`endif
      offer(pc, t);
    end
    drain();
`ifdef TRACE_DROP_EN
    chk(drop_count == 16'(drops_exp), "drop_count_final", drop_count, drops_exp);
`endif

    // Reset in the middle of a line.
    rdy_mode = 1;
    base = bytes_seen;
    offer(10'h012, t027);
    c = 0;
    while (bytes_seen - base < 5 && c < 200) begin @(negedge clk); #1; c++; end
    chk(c < 200, "reset_wait_timeout", c, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk(bus.char_valid == 1'b0, "midreset_char_valid", bus.char_valid, 0);
    chk(bus.char_data == 8'h00, "midreset_char_data", bus.char_data, 0);
    chk(bus.trace_ready == 1'b1, "midreset_trace_ready", bus.trace_ready, 1);
`ifdef TRACE_DROP_EN
    chk(drop_count == 16'h0, "midreset_drop_count", drop_count, 0);
`endif
    exp_q.delete();
    done_lines = pushed_lines;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base = bytes_seen;
    repeat (40) @(posedge clk);
    #1;
    chk(bytes_seen == base, "silent_after_reset", bytes_seen - base, 0);
    chk(bus.char_valid == 1'b0, "idle_after_reset", bus.char_valid, 0);

    offer(10'h0AB, build_text("NOP"));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
